led_disp_scan: RTL and testbench
================================

# led_disp_scan

Parametrised multiplexed seven-segment scan driver that generalises the fixed six-digit display scanner. It time-multiplexes `NUM_DIGITS` digits onto one shared segment bus. It adds per-digit blanking, per-digit blinking, PWM brightness control and frame-coherent input latching. It sits between the `fnd_dec` segment decoders and the board's common-node and segment pins.

## Interface
- `NUM_DIGITS`, 6: digits scanned; legal range 1..16.
- `SCAN_DIV`, 50000: clk cycles per digit slot; must be ≥ 2^`PWM_BITS` and ≥ 2.
- `PWM_BITS`, 4: brightness resolution in bits.
- `BLINK_FRAMES`, 250: frames per blink half-period; must be ≥ 1.
- `clk` in 1: single clock.
- `rst` in 1: reset. Synchronous and active-high.
- `i_digit_seg` in 7*`NUM_DIGITS`: digit k segments at `[7k+6:7k]`, ordered {a..g}, active-high.
- `i_dp` in `NUM_DIGITS`: decimal point per digit.
- `i_digit_en` in `NUM_DIGITS`: 1 = digit shown, 0 = blanked.
- `i_blink` in `NUM_DIGITS`: 1 = digit blinks.
- `i_bright` in `PWM_BITS`: brightness level.
- `o_seg` out 7: shared segment bus.
- `o_seg_dp` out 1: shared decimal point.
- `o_seg_enb` out `NUM_DIGITS`: common-node enables, active-low, one-hot-low or all ones.
- `o_frame` out 1: one-cycle pulse at the start of each frame.

## Operation
- Prescaler `div_cnt` counts 0..`SCAN_DIV`-1 and wraps. `tick` = (`div_cnt` == `SCAN_DIV`-1).
- Digit index `idx` advances on `tick` and wraps from `NUM_DIGITS`-1 to 0. A frame is `NUM_DIGITS` slots.
- Shadow registers hold `i_digit_seg`, `i_dp`, `i_digit_en`, `i_blink` and `i_bright`.
  - They load in the first cycle after `rst` deasserts.
  - They also load on every `tick` where `idx` == `NUM_DIGITS`-1 (frame wrap).
  - Input changes mid-frame never reach the outputs until the next frame.
- Blink:
  - `blink_cnt` counts frames 0..`BLINK_FRAMES`-1.
  - `blink_on` toggles when `blink_cnt` wraps.
  - Reset sets `blink_on`=1 (visible).
- Digit k is lit in a given cycle when all of the following hold:
  - `idx`==k
  - shadow `i_digit_en[k]`=1
  - shadow `i_blink[k]`=0 or `blink_on`=1
  - `div_cnt[PWM_BITS-1:0]` ≤ shadow `i_bright`
- Brightness duty = (`i_bright`+1)/2^`PWM_BITS`. Maximum level = 100%.
- When lit:
  - `o_seg_enb[k]`=0 and all other enable bits are 1.
  - `o_seg` = shadow segments of digit k.
  - `o_seg_dp` = shadow dp of digit k.
- When not lit: `o_seg_enb` = all ones, `o_seg`=0, `o_seg_dp`=0. Segments never drive while enables are off (ghosting rule).
- `NUM_DIGITS`=1: `idx` stays 0, and every `tick` is a frame wrap.

## Timing
- All outputs are registered and reflect the internal state (`idx`, `div_cnt`, shadow) of the previous cycle. Latency is 1 cycle.
- Reset values: `o_seg`=7'd0, `o_seg_dp`=0, `o_seg_enb`=all ones, `o_frame`=0, `idx`=0, `div_cnt`=0, `blink_cnt`=0, `blink_on`=1, shadows=0.
- `rst` asserted mid-frame:
  - The next edge forces every reset value.
  - The scan restarts at digit 0 after deassert.
  - The shadow loads at the first post-reset cycle (cycle 0).
  - Digit 0 output is visible at cycle 1.
- `o_frame` is high for exactly 1 cycle. It occurs in the cycle after each wrap `tick` and in the first output cycle after reset release.
- Slot k output spans `SCAN_DIV` consecutive cycles. Enable transitions happen on the same edge as segment transitions.
- `blink_on` toggles on the same edge as the frame wrap that ends frame `BLINK_FRAMES`-1.
- Simultaneous frame wrap and input change: the value present at the wrap edge is captured.

## Test plan
Unless stated otherwise, all scenarios use `NUM_DIGITS`=4, `SCAN_DIV`=16, `PWM_BITS`=2, `BLINK_FRAMES`=2.
- Basic scan:
  - Stimulus: `i_bright`=3, all enabled, digits = patterns 0x7E, 0x30, 0x6D, 0x79.
  - Required response: `o_seg_enb` walks 1110→1101→1011→0111, 16 cycles each. `o_seg` matches the pattern for each digit. `o_frame` pulses every 64 cycles.
- PWM:
  - Stimulus: `i_bright`=1.
  - Required response: each slot is lit for `div_cnt` low bits 0,1 and dark for 2,3. That is 8 of 16 cycles. `o_seg`=0 whenever dark.
- Blank/blink:
  - Stimulus: `i_digit_en`=4'b1011, `i_blink`=4'b0001.
  - Required response: digit 2 is never enabled. Digit 0 is lit in frames 0–1, dark in frames 2–3, lit again in frames 4–5.
- Frame coherence:
  - Stimulus: change digit 3 from 0x79 to 0x33 while `idx`=1.
  - Required response: the current frame still shows 0x79. The next frame shows 0x33.
- Reset mid-frame:
  - Stimulus: assert `rst` for 1 cycle while `idx`=2.
  - Required response: the next cycle shows all reset values. The cycle after deassert loads the shadow. Digit 0 is visible 1 cycle later with `o_frame`=1.
- Single digit:
  - Stimulus: `NUM_DIGITS`=1.
  - Required response: `o_seg_enb`=0 whenever lit. `o_frame` pulses every 16 cycles.

Source files
------------

// File: rtl/led_disp_scan_if.sv
// led_disp_scan_if: display-data and pin-side signal bundle for led_disp_scan.
//   digit_seg : 7*NUM_DIGITS segment patterns, digit k at [7k+6:7k], {a..g}
//   dp        : decimal point per digit
//   digit_en  : 1 = digit shown, 0 = blanked
//   blink     : 1 = digit blinks
//   bright    : PWM brightness level, duty = (bright+1)/2^PWM_BITS
//   seg       : shared segment bus (active-high)
//   seg_dp    : shared decimal point
//   seg_enb   : common-node enables, active-low, one-hot-low or all ones
//   frame     : one-cycle pulse on the first output cycle of each frame
// master = display-data source / pin consumer, slave = the scanner.
interface led_disp_scan_if #(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned PWM_BITS   = 4
);
   logic [7*NUM_DIGITS-1:0] digit_seg;
   logic [NUM_DIGITS-1:0]   dp;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic [NUM_DIGITS-1:0]   blink;
   logic [PWM_BITS-1:0]     bright;
   logic [6:0]              seg;
   logic                    seg_dp;
   logic [NUM_DIGITS-1:0]   seg_enb;
   logic                    frame;

   modport master (
      output digit_seg, dp, digit_en, blink, bright,
      input  seg, seg_dp, seg_enb, frame
   );

   modport slave (
      input  digit_seg, dp, digit_en, blink, bright,
      output seg, seg_dp, seg_enb, frame
   );
endinterface

// File: rtl/led_disp_scan.sv
// led_disp_scan: multiplexed seven-segment scan driver.
// Time-multiplexes NUM_DIGITS digits onto one segment bus with per-digit
// blanking and blinking, PWM brightness, and frame-coherent input latching.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : led_disp_scan_if.slave (display data in, segment/enable pins out)
// All outputs are registered from the previous cycle's scan state.
module led_disp_scan #(
   parameter int unsigned NUM_DIGITS   = 6,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned PWM_BITS     = 4,
   parameter int unsigned BLINK_FRAMES = 250
) (
   input logic           clk,
   input logic           rst,
   led_disp_scan_if.slave bus
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned DIV_W = $clog2(SCAN_DIV);
   localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

   // scan state
   logic [DIV_W-1:0] div_cnt;
   logic [IDX_W-1:0] idx;
   logic [BLK_W-1:0] blink_cnt;
   logic             blink_on;
   logic             load_pend;   // first cycle after reset: capture shadow, hold scan

   // shadow copies of the display inputs, refreshed once per frame
   logic [7*NUM_DIGITS-1:0] seg_sh;
   logic [NUM_DIGITS-1:0]   dp_sh;
   logic [NUM_DIGITS-1:0]   en_sh;
   logic [NUM_DIGITS-1:0]   blink_sh;
   logic [PWM_BITS-1:0]     bright_sh;

   logic                  tick;
   logic                  wrap;
   logic                  lit;
   logic                  frame_start;
   logic [6:0]            sel_seg;
   logic                  sel_dp;
   logic                  sel_en;
   logic                  sel_blink;
   logic [NUM_DIGITS-1:0] enb_next;

   assign tick        = (div_cnt == DIV_LAST);
   assign wrap        = !load_pend && tick && (idx == IDX_LAST);
   assign frame_start = !load_pend && (idx == '0) && (div_cnt == '0);

   // select the shadow data of the digit currently being scanned
   always_comb begin
      sel_seg   = '0;
      sel_dp    = 1'b0;
      sel_en    = 1'b0;
      sel_blink = 1'b0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (32'(idx) == k) begin
            sel_seg   = seg_sh[7*k +: 7];
            sel_dp    = dp_sh[k];
            sel_en    = en_sh[k];
            sel_blink = blink_sh[k];
         end
      end
   end

   // PWM gate compares the low prescaler bits against the level, so
   // level 2^PWM_BITS-1 is lit for every cycle of the slot.
   assign lit = !load_pend && sel_en && (!sel_blink || blink_on) &&
                (div_cnt[PWM_BITS-1:0] <= bright_sh);

   always_comb begin
      enb_next = '1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (lit && (32'(idx) == k)) begin
            enb_next[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt     <= '0;
         idx         <= '0;
         blink_cnt   <= '0;
         blink_on    <= 1'b1;
         load_pend   <= 1'b1;
         seg_sh      <= '0;
         dp_sh       <= '0;
         en_sh       <= '0;
         blink_sh    <= '0;
         bright_sh   <= '0;
         bus.seg     <= '0;
         bus.seg_dp  <= 1'b0;
         bus.seg_enb <= '1;
         bus.frame   <= 1'b0;
      end else begin
         // segments are forced to zero whenever no enable is asserted
         bus.seg     <= lit ? sel_seg : '0;
         bus.seg_dp  <= lit && sel_dp;
         bus.seg_enb <= enb_next;
         bus.frame   <= frame_start;

         if (load_pend || wrap) begin
            seg_sh    <= bus.digit_seg;
            dp_sh     <= bus.dp;
            en_sh     <= bus.digit_en;
            blink_sh  <= bus.blink;
            bright_sh <= bus.bright;
         end

         // The scan holds at digit 0 / count 0 during the post-reset load
         // cycle so the first frame starts with a full slot of digit 0.
         if (load_pend) begin
            load_pend <= 1'b0;
         end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
               idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (wrap) begin
               if (blink_cnt == BLK_LAST) begin
                  blink_cnt <= '0;
                  blink_on  <= ~blink_on;
               end else begin
                  blink_cnt <= blink_cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_led_disp_scan.sv
// tb_led_disp_scan: directed self-checking bench for led_disp_scan.
// Two instances: a 4-digit scanner and a 1-digit scanner, both with
// SCAN_DIV=16, PWM_BITS=2, BLINK_FRAMES=2.
module tb_led_disp_scan;

   logic clk = 1'b0;
   logic rst;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   led_disp_scan_if #(.NUM_DIGITS(4), .PWM_BITS(2)) bus4 ();
   led_disp_scan_if #(.NUM_DIGITS(1), .PWM_BITS(2)) bus1 ();

   led_disp_scan #(
      .NUM_DIGITS(4), .SCAN_DIV(16), .PWM_BITS(2), .BLINK_FRAMES(2)
   ) dut4 (
      .clk(clk), .rst(rst), .bus(bus4)
   );

   led_disp_scan #(
      .NUM_DIGITS(1), .SCAN_DIV(16), .PWM_BITS(2), .BLINK_FRAMES(2)
   ) dut1 (
      .clk(clk), .rst(rst), .bus(bus1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Digit patterns held in the shadow during frame f of the main run.
   function automatic logic [6:0] pat(input int slot, input int f);
      case (slot)
         0:       return 7'h7E;
         1:       return 7'h30;
         2:       return 7'h6D;
         default: return (f < 5) ? 7'h79 : 7'h33;
      endcase
   endfunction

   initial begin
      rst            = 1'b1;
      bus4.digit_seg = {7'h79, 7'h6D, 7'h30, 7'h7E};
      bus4.dp        = 4'b0010;
      bus4.digit_en  = 4'b1111;
      bus4.blink     = 4'b0000;
      bus4.bright    = 2'd3;
      bus1.digit_seg = 7'h77;
      bus1.dp        = 1'b1;
      bus1.digit_en  = 1'b1;
      bus1.blink     = 1'b0;
      bus1.bright    = 2'd3;

      step();
      step();
      chk("rst seg",     32'(bus4.seg),     32'h0);
      chk("rst dp",      32'(bus4.seg_dp),  32'h0);
      chk("rst enb",     32'(bus4.seg_enb), 32'hF);
      chk("rst frame",   32'(bus4.frame),   32'h0);
      chk("rst enb n1",  32'(bus1.seg_enb), 32'h1);

      rst = 1'b0;
      step();   // shadow load cycle, still dark
      chk("load enb",   32'(bus4.seg_enb), 32'hF);
      chk("load frame", 32'(bus4.frame),   32'h0);
      chk("load seg",   32'(bus4.seg),     32'h0);

      // t = output cycles since the first visible cycle of digit 0
      for (int t = 0; t < 420; t++) begin
         int f, slot, dc;
         logic [3:0] en, bl;
         int br;
         logic bon, lit;
         logic [3:0] e_enb;
         logic [6:0] e_seg;

         step();
         f    = t / 64;
         slot = (t / 16) % 4;
         dc   = t % 16;
         en   = (f < 2) ? 4'hF : 4'hB;
         bl   = (f < 2) ? 4'h0 : 4'h1;
         br   = (f == 1) ? 1 : 3;
         bon  = ((f / 2) % 2) == 0;
         lit  = en[slot] && (!bl[slot] || bon) && ((dc % 4) <= br);
         e_enb = lit ? ~(4'b0001 << slot) : 4'hF;
         e_seg = lit ? pat(slot, f) : 7'h0;

         chk($sformatf("enb t=%0d", t),   32'(bus4.seg_enb), 32'(e_enb));
         chk($sformatf("seg t=%0d", t),   32'(bus4.seg),     32'(e_seg));
         chk($sformatf("dp t=%0d", t),    32'(bus4.seg_dp),  32'(lit && slot == 1));
         chk($sformatf("frame t=%0d", t), 32'(bus4.frame),   32'(t % 64 == 0));

         if (t < 64) begin
            chk($sformatf("n1 enb t=%0d", t),   32'(bus1.seg_enb), 32'h0);
            chk($sformatf("n1 seg t=%0d", t),   32'(bus1.seg),     32'h77);
            chk($sformatf("n1 dp t=%0d", t),    32'(bus1.seg_dp),  32'h1);
            chk($sformatf("n1 frame t=%0d", t), 32'(bus1.frame),   32'(t % 16 == 0));
         end

         // stimulus changes, each taking effect at the next frame
         if (t == 0) begin
            bus4.bright = 2'd1;
         end
         if (t == 64) begin
            bus4.bright   = 2'd3;
            bus4.digit_en = 4'b1011;
            bus4.blink    = 4'b0001;
         end
         if (t == 276) begin
            bus4.digit_seg[27:21] = 7'h33;
         end
      end

      // last sample above was digit 2's slot of frame 6: reset mid-frame
      rst = 1'b1;
      bus4.digit_seg[6:0] = 7'h5B;
      step();
      chk("mid rst seg",   32'(bus4.seg),     32'h0);
      chk("mid rst dp",    32'(bus4.seg_dp),  32'h0);
      chk("mid rst enb",   32'(bus4.seg_enb), 32'hF);
      chk("mid rst frame", 32'(bus4.frame),   32'h0);
      rst = 1'b0;
      step();
      chk("mid load enb",   32'(bus4.seg_enb), 32'hF);
      chk("mid load frame", 32'(bus4.frame),   32'h0);
      step();
      chk("post rst enb",   32'(bus4.seg_enb), 32'hE);
      chk("post rst seg",   32'(bus4.seg),     32'h5B);
      chk("post rst frame", 32'(bus4.frame),   32'h1);
      repeat (16) step();
      chk("post rst enb d1", 32'(bus4.seg_enb), 32'hD);
      chk("post rst seg d1", 32'(bus4.seg),     32'h30);
      chk("post rst dp d1",  32'(bus4.seg_dp),  32'h1);
      repeat (16) step();
      chk("post rst enb d2", 32'(bus4.seg_enb), 32'hF);
      chk("post rst seg d2", 32'(bus4.seg),     32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
